// File: rtl/vga_pkg.sv
// Default 640x480@60 timing constants, coordinate type and sync polarities.
// Constants only; no latency, no backpressure.
package vga_pkg;
  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [9:0] coord_t;

  localparam logic SYNC_ACTIVE = 1'b0;
  localparam logic SYNC_IDLE   = 1'b1;
endpackage

// File: rtl/delay_line.sv
// Fixed-depth shift register with a per-bit reset pattern.
// Latency DEPTH cycles; always accepts input, no backpressure.
module delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             core_clk,
  input  logic             arst_n,
  input  logic [WIDTH-1:0] din_dat,
  output logic [WIDTH-1:0] dout_dat
);
  logic [WIDTH-1:0] stage_q [DEPTH];
  logic [WIDTH-1:0] stage_d [DEPTH];

  always_comb begin
    stage_d[0] = din_dat;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= RESET_VAL;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign dout_dat = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel divider, h/v counters, pixel clock, sync/blank and frame_start.
// Counters/frame_start update on the pixel edge; sync/blank lag by PIPE_DELAY Clk; free-running.
module vga_timing_gen #(
  parameter int H_VISIBLE  = vga_pkg::H_VISIBLE,
  parameter int H_FP       = vga_pkg::H_FP,
  parameter int H_SYNC     = vga_pkg::H_SYNC,
  parameter int H_BP       = vga_pkg::H_BP,
  parameter int V_VISIBLE  = vga_pkg::V_VISIBLE,
  parameter int V_FP       = vga_pkg::V_FP,
  parameter int V_SYNC     = vga_pkg::V_SYNC,
  parameter int V_BP       = vga_pkg::V_BP,
  parameter int CLK_DIV    = 2,
  parameter int PIPE_DELAY = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       VGA_CLK,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic       frame_start
);
  import vga_pkg::*;

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t H_LAST     = coord_t'(H_TOT - 1);
  localparam coord_t V_LAST     = coord_t'(V_TOT - 1);
  localparam coord_t H_VIS_END  = coord_t'(H_VISIBLE);
  localparam coord_t V_VIS_END  = coord_t'(V_VISIBLE);
  localparam coord_t V_VIS_LAST = coord_t'(V_VISIBLE - 1);
  localparam coord_t HS_START   = coord_t'(H_VISIBLE + H_FP);
  localparam coord_t HS_END     = coord_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_t VS_START   = coord_t'(V_VISIBLE + V_FP);
  localparam coord_t VS_END     = coord_t'(V_VISIBLE + V_FP + V_SYNC);

  localparam logic [1:0] DIV_LAST = 2'(CLK_DIV - 1);
  localparam logic [1:0] DIV_HALF = 2'(CLK_DIV / 2);

  // Delay-line bit order is {hs, vs, blank_n}; reset leaves syncs idle and blanked.
  localparam logic [2:0] PIPE_RESET = {SYNC_IDLE, SYNC_IDLE, 1'b0};

  logic [1:0] div_q, div_d;
  coord_t     h_cnt_q, h_cnt_d;
  coord_t     v_cnt_q, v_cnt_d;
  logic       vga_clk_q, vga_clk_d;
  logic       frame_start_q, frame_start_d;
  logic       pix_tick;
  logic       hs_raw, vs_raw, blank_raw;

  assign pix_tick = (div_q == DIV_LAST);

  always_comb begin
    div_d         = pix_tick ? 2'd0 : div_q + 2'd1;
    h_cnt_d       = h_cnt_q;
    v_cnt_d       = v_cnt_q;
    frame_start_d = 1'b0;
    if (pix_tick) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d       = '0;
        v_cnt_d       = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        frame_start_d = (v_cnt_q == V_VIS_LAST);
      end else begin
        h_cnt_d = h_cnt_q + 10'd1;
      end
    end
    // High in the second half of the pixel so the DAC samples late.
    vga_clk_d = (div_d >= DIV_HALF);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q         <= '0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      vga_clk_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      vga_clk_q     <= vga_clk_d;
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    hs_raw    = (h_cnt_q >= HS_START && h_cnt_q < HS_END) ? SYNC_ACTIVE : SYNC_IDLE;
    vs_raw    = (v_cnt_q >= VS_START && v_cnt_q < VS_END) ? SYNC_ACTIVE : SYNC_IDLE;
    blank_raw = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
  end

  delay_line #(
    .WIDTH     (3),
    .DEPTH     (PIPE_DELAY),
    .RESET_VAL (PIPE_RESET)
  ) u_sync_dly (
    .core_clk (Clk),
    .arst_n   (Reset_n),
    .din_dat  ({hs_raw, vs_raw, blank_raw}),
    .dout_dat ({VGA_HS, VGA_VS, VGA_BLANK_N})
  );

  assign DrawX       = h_cnt_q;
  assign DrawY       = v_cnt_q;
  assign VGA_CLK     = vga_clk_q;
  assign VGA_SYNC_N  = 1'b0;
  assign frame_start = frame_start_q;
endmodule
